// File: rtl/addsub_nibble_seq.sv
// addsub_nibble_seq: multi-word add/subtract sequencer driving a 4-bit slice.
// Processes a WIDTH-bit operation one nibble per clock, LSB nibble first,
// with a registered carry between nibbles. Subtraction is B-invert plus
// carry-in of 1.
//
// Optional build macro: ADDSUB_OVF_DET_EN
//   defined   -> overflow reports signed two's-complement overflow
//   undefined -> overflow is tied to 0 (port kept)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; outputs hold last result
// RUN   | one nibble written per cycle, LSB first; busy=1
// DONE  | single cycle, done=1; start here re-accepts back-to-back

module addsub_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NIBS  = WIDTH / 4;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             last_nib;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       nib_sum;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_nib = (idx == IDX_W'(NIBS - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // Nibble slice: selected operand nibbles, B conditionally inverted.
  always_comb begin
    a_nib   = a_q[4*idx +: 4];
    b_nib   = b_q[4*idx +: 4] ^ {4{mode_q}};
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; start is ignored while RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, nibble write-back and carry chain during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      carry_q   <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      mode_q  <= mode;
      carry_q <= mode;
      idx     <= '0;
    end else if (state == RUN) begin
      result[4*idx +: 4] <= nib_sum[3:0];
      carry_q            <= nib_sum[4];
      idx                <= idx + 1'b1;
      if (last_nib) carry_out <= nib_sum[4];
    end
  end

`ifdef ADDSUB_OVF_DET_EN
  logic [3:0] low_sum;
  logic       msb_cin;
  logic       ovf_q;

  // Carry into the MSB comes from the low three bits of the top nibble.
  always_comb begin
    low_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    msb_cin = low_sum[3];
  end

  // Overflow registered alongside carry_out on the final nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ovf_q <= 1'b0;
    else if (state == RUN && last_nib) ovf_q <= msb_cin ^ nib_sum[4];
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
